// File: rtl/tx_packet_gen.sv
`default_nettype none
// ============================================================================
// Module   : tx_packet_gen
// Function : AXI4-Stream burst packet generator with receiver-matched counters.
//            Define TX_PRBS_EN to replace the seq/beat payload with PRBS-31 lanes.
// Revision : 1.0  initial release
// ============================================================================
module tx_packet_gen #(
    parameter int DW = 512
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            stop,
    input  logic [1:0]      cfg_type,
    input  logic [15:0]     cfg_length,
    input  logic [31:0]     cfg_count,
    input  logic [15:0]     cfg_gap,
    input  logic            cfg_bad,
    input  logic [7:0]      port_number,
    output logic            busy,
    output logic [63:0]     fd_sent,
    output logic [63:0]     md_sent,
    output logic [63:0]     fc_sent,
    output logic [63:0]     oth_sent,
    output logic [63:0]     bad_sent,
    output logic [DW-1:0]   axis_tdata,
    output logic [DW/8-1:0] axis_tkeep,
    output logic            axis_tlast,
    output logic            axis_tuser,
    output logic            axis_tvalid,
    input  logic            axis_tready
);

    localparam int BPB   = DW / 8;
    localparam int LANES = DW / 32;
    localparam int BW    = $clog2(BPB);
    localparam int KW    = BW + 1;

    localparam logic [15:0] LEN_FD = 16'd4160;
    localparam logic [15:0] LEN_MD = 16'd192;
    localparam logic [15:0] LEN_FC = 16'd68;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   len_q;
    logic [15:0]   gap_q;
    logic [15:0]   last_idx_q;
    logic [15:0]   beat_q;
    logic [15:0]   seq_q;
    logic [15:0]   gap_cnt_q;
    logic [31:0]   count_q;
    logic [31:0]   sent_q;
    logic          bad_q;
    logic          stop_pend_q;
    logic [7:0]    port_q;
    logic [KW-1:0] last_k_q;
    logic [63:0]   fd_q, md_q, fc_q, oth_q, bad_cnt_q;

    logic [15:0]   w_len_start;
    logic [15:0]   w_len_m1;
    logic          w_start;
    logic          w_valid;
    logic          w_hs;
    logic          w_last;
    logic          w_pkt_done;
    logic          w_stop;
    logic          w_burst_end;
    logic [DW-1:0] w_tdata;
    logic [BPB-1:0] w_tkeep;

    always_comb begin
        w_len_start = LEN_FD;
        case (cfg_type)
            2'd0:    w_len_start = LEN_FD;
            2'd1:    w_len_start = LEN_MD;
            2'd2:    w_len_start = LEN_FC;
            default: w_len_start = (cfg_length == 16'd0) ? 16'd1 : cfg_length;
        endcase
    end

    assign w_len_m1    = w_len_start - 16'd1;
    assign w_start     = (state_q == ST_IDLE) && start;
    assign w_valid     = (state_q == ST_SEND);
    assign w_hs        = w_valid && axis_tready;
    assign w_last      = (beat_q == last_idx_q);
    assign w_pkt_done  = w_hs && w_last;
    assign w_stop      = stop_pend_q || stop;
    assign w_burst_end = (count_q != 32'd0) && ((sent_q + 32'd1) == count_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (w_pkt_done) begin
                    if (w_stop || w_burst_end) state_d = ST_IDLE;
                    else if (gap_q != 16'd0)   state_d = ST_GAP;
                    else                       state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                if (w_stop)                   state_d = ST_IDLE;
                else if (gap_cnt_q == 16'd0)  state_d = ST_SEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            len_q       <= '0;
            gap_q       <= '0;
            last_idx_q  <= '0;
            beat_q      <= '0;
            seq_q       <= '0;
            gap_cnt_q   <= '0;
            count_q     <= '0;
            sent_q      <= '0;
            bad_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            port_q      <= '0;
            last_k_q    <= '0;
            fd_q        <= '0;
            md_q        <= '0;
            fc_q        <= '0;
            oth_q       <= '0;
            bad_cnt_q   <= '0;
        end else if (w_start) begin
            len_q       <= w_len_start;
            gap_q       <= cfg_gap;
            count_q     <= cfg_count;
            bad_q       <= cfg_bad;
            port_q      <= port_number;
            last_idx_q  <= w_len_m1 >> BW;
            last_k_q    <= {1'b0, w_len_m1[BW-1:0]} + KW'(1);
            beat_q      <= '0;
            seq_q       <= '0;
            sent_q      <= '0;
            stop_pend_q <= stop;
        end else begin
            if (stop && state_q != ST_IDLE) stop_pend_q <= 1'b1;
            if (w_hs) beat_q <= w_last ? 16'd0 : beat_q + 16'd1;
            if (w_pkt_done) begin
                seq_q  <= seq_q + 16'd1;
                sent_q <= sent_q + 32'd1;
                // Classification matches the receiver so loopback totals line up.
                if (bad_q)                 bad_cnt_q <= bad_cnt_q + 64'd1;
                else if (len_q == LEN_FD)  fd_q      <= fd_q + 64'd1;
                else if (len_q == LEN_MD)  md_q      <= md_q + 64'd1;
                else if (len_q == LEN_FC)  fc_q      <= fc_q + 64'd1;
                else                       oth_q     <= oth_q + 64'd1;
            end
            if (state_q == ST_SEND && state_d == ST_GAP) gap_cnt_q <= gap_q - 16'd1;
            else if (state_q == ST_GAP)                  gap_cnt_q <= gap_cnt_q - 16'd1;
            if (state_q != ST_IDLE && state_d == ST_IDLE) stop_pend_q <= 1'b0;
        end
    end

`ifdef TX_PRBS_EN
    logic [31:0] lfsr_q;
    logic [31:0] w_lane_st [LANES+1];

    assign w_lane_st[0] = lfsr_q;
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lfsr
        assign w_lane_st[gi+1] = {w_lane_st[gi][30:0], w_lane_st[gi][30] ^ w_lane_st[gi][27]};
    end

    always_ff @(posedge clk) begin
        if (!resetn)   lfsr_q <= '0;
        else if (w_start) lfsr_q <= 32'h1;
        else if (w_hs)    lfsr_q <= w_lane_st[LANES];
    end
`endif

    always_comb begin
        w_tdata = '0;
        if (w_valid) begin
            for (int i = 0; i < LANES; i++) begin
`ifdef TX_PRBS_EN
                w_tdata[i*32 +: 32] = w_lane_st[i];
`else
                w_tdata[i*32 +: 32] = {seq_q, beat_q};
`endif
            end
            if (beat_q == 16'd0) w_tdata[7:0] = port_q;
        end
    end

    always_comb begin
        w_tkeep = '0;
        for (int b = 0; b < BPB; b++) begin
            w_tkeep[b] = w_valid && (!w_last || (b < int'(last_k_q)));
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign axis_tvalid = w_valid;
    assign axis_tdata  = w_tdata;
    assign axis_tkeep  = w_tkeep;
    assign axis_tlast  = w_valid && w_last;
    assign axis_tuser  = w_valid && w_last && bad_q;
    assign fd_sent     = fd_q;
    assign md_sent     = md_q;
    assign fc_sent     = fc_q;
    assign oth_sent    = oth_q;
    assign bad_sent    = bad_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_packet_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_packet_gen
// Function : Randomized self-checking bench for tx_packet_gen against a
//            packet-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_tx_packet_gen;

    localparam int DW  = 512;
    localparam int BPB = DW / 8;

    logic            clk = 1'b0;
    logic            resetn;
    logic            start, stop;
    logic [1:0]      cfg_type;
    logic [15:0]     cfg_length;
    logic [31:0]     cfg_count;
    logic [15:0]     cfg_gap;
    logic            cfg_bad;
    logic [7:0]      port_number;
    logic            busy;
    logic [63:0]     fd_sent, md_sent, fc_sent, oth_sent, bad_sent;
    logic [DW-1:0]   axis_tdata;
    logic [BPB-1:0]  axis_tkeep;
    logic            axis_tlast, axis_tuser, axis_tvalid, axis_tready;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] m_fd, m_md, m_fc, m_oth, m_bad;
    logic [31:0] m_lfsr;

    tx_packet_gen #(.DW(DW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .cfg_type(cfg_type), .cfg_length(cfg_length), .cfg_count(cfg_count),
        .cfg_gap(cfg_gap), .cfg_bad(cfg_bad), .port_number(port_number),
        .busy(busy), .fd_sent(fd_sent), .md_sent(md_sent), .fc_sent(fc_sent),
        .oth_sent(oth_sent), .bad_sent(bad_sent),
        .axis_tdata(axis_tdata), .axis_tkeep(axis_tkeep), .axis_tlast(axis_tlast),
        .axis_tuser(axis_tuser), .axis_tvalid(axis_tvalid), .axis_tready(axis_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[30] ^ s[27]};
    endfunction

    function automatic logic [DW-1:0] exp_data(input int seq, input int beat, input logic [7:0] port);
        logic [DW-1:0] d;
        logic [31:0]   s;
        s = m_lfsr;
        for (int i = 0; i < DW/32; i++) begin
`ifdef TX_PRBS_EN
            d[i*32 +: 32] = s;
            s = lfsr_step(s);
`else
            d[i*32 +: 32] = {seq[15:0], beat[15:0]};
`endif
        end
        if (beat == 0) d[7:0] = port;
        return d;
    endfunction

    function automatic logic [BPB-1:0] exp_keep(input int len, input int beat);
        logic [BPB-1:0] k;
        int left;
        left = len - beat * BPB;
        for (int b = 0; b < BPB; b++) k[b] = (b < left);
        return k;
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_fd"},  DW'(fd_sent),  DW'(m_fd));
        check({tag, "_md"},  DW'(md_sent),  DW'(m_md));
        check({tag, "_fc"},  DW'(fc_sent),  DW'(m_fc));
        check({tag, "_oth"}, DW'(oth_sent), DW'(m_oth));
        check({tag, "_bad"}, DW'(bad_sent), DW'(m_bad));
    endtask

    // stop_pkt: -1 none, -2 together with start, else packet index to stop in.
    // rst_beat: -1 none, else beat index of the first packet at which to reset.
    task automatic run_burst(input int typ, input int clen, input int cnt, input int gap,
                             input bit bad, input bit rnd_rdy, input int stop_pkt,
                             input int stop_beat, input int rst_beat);
        int len, nb, pkts, beat, idle, cyc;
        bit stop_req, stop_done, done, wait_first, last;
        logic [7:0] port;
        len  = (typ == 0) ? 4160 : (typ == 1) ? 192 : (typ == 2) ? 68 : ((clen == 0) ? 1 : clen);
        nb   = (len + BPB - 1) / BPB;
        port = 8'($urandom_range(0, 255));
        cfg_type = 2'(typ); cfg_length = 16'(clen); cfg_count = 32'(cnt);
        cfg_gap = 16'(gap); cfg_bad = bad; port_number = port;
        start = 1'b1;
        stop  = (stop_pkt == -2);
        stop_req = stop; stop_done = 1'b0;
        m_lfsr = 32'h1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        // Config must already be latched; scramble the inputs.
        cfg_type = 2'($urandom); cfg_length = 16'($urandom); cfg_count = $urandom;
        cfg_gap = 16'($urandom); cfg_bad = 1'($urandom); port_number = 8'($urandom);
        check("start_latency", DW'(axis_tvalid), DW'(1));
        pkts = 0; beat = 0; idle = 0; cyc = 0; done = 1'b0; wait_first = 1'b0;
        while (!done) begin
            if (cyc > 20000) begin
                check("timeout", DW'(0), DW'(1));
                return;
            end
            cyc++;
            axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            stop = 1'b0;
            if (rst_beat >= 0 && axis_tvalid && beat == rst_beat) begin
                resetn = 1'b0;
                m_fd = 0; m_md = 0; m_fc = 0; m_oth = 0; m_bad = 0;
                @(negedge clk);
                check("rst_tvalid", DW'(axis_tvalid), DW'(0));
                check("rst_busy", DW'(busy), DW'(0));
                check_counters("rst");
                resetn = 1'b1;
                return;
            end
            if (!stop_done && stop_pkt == pkts && beat == stop_beat && axis_tvalid) begin
                stop = 1'b1; stop_req = 1'b1; stop_done = 1'b1;
            end
            check("busy", DW'(busy), DW'(1));
            if (axis_tvalid) begin
                if (wait_first) begin
                    check("gap_idle", DW'(idle), DW'(gap));
                    wait_first = 1'b0;
                end
                last = (beat == nb - 1);
                check("tdata", axis_tdata, exp_data(pkts, beat, port));
                check("tkeep", DW'(axis_tkeep), DW'(exp_keep(len, beat)));
                check("tlast", DW'(axis_tlast), DW'(last));
                check("tuser", DW'(axis_tuser), DW'(bad && last));
                if (axis_tready) begin
                    for (int i = 0; i < DW/32; i++) m_lfsr = lfsr_step(m_lfsr);
                    if (last) begin
                        pkts++; beat = 0;
                        if (bad)              m_bad++;
                        else if (len == 4160) m_fd++;
                        else if (len == 192)  m_md++;
                        else if (len == 68)   m_fc++;
                        else                  m_oth++;
                        if ((cnt != 0 && pkts == cnt) || stop_req) done = 1'b1;
                        else begin
                            wait_first = 1'b1; idle = 0;
                        end
                    end else begin
                        beat++;
                    end
                end
            end else if (wait_first) begin
                idle++;
            end else begin
                check("tvalid_in_pkt", DW'(axis_tvalid), DW'(1));
            end
            @(negedge clk);
        end
        stop = 1'b0;
        axis_tready = 1'b1;
        check("busy_end", DW'(busy), DW'(0));
        check("tvalid_end", DW'(axis_tvalid), DW'(0));
        check_counters("burst");
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_type = '0; cfg_length = '0; cfg_count = '0; cfg_gap = '0;
        cfg_bad = 1'b0; port_number = '0; axis_tready = 1'b1;
        m_fd = 0; m_md = 0; m_fc = 0; m_oth = 0; m_bad = 0; m_lfsr = 32'h1;
        repeat (3) @(negedge clk);
        check("reset_tvalid", DW'(axis_tvalid), DW'(0));
        check("reset_busy", DW'(busy), DW'(0));
        check("reset_tdata", axis_tdata, DW'(0));
        check("reset_tkeep", DW'(axis_tkeep), DW'(0));
        check("reset_tlast", DW'(axis_tlast), DW'(0));
        check("reset_tuser", DW'(axis_tuser), DW'(0));
        check_counters("reset");
        resetn = 1'b1;
        @(negedge clk);

        run_burst(0, 0, 1, 0, 1'b0, 1'b0, -1, -1, -1);   // FD single packet
        run_burst(2, 0, 3, 5, 1'b0, 1'b0, -1, -1, -1);   // FC with gap 5
        run_burst(1, 0, 2, 2, 1'b0, 1'b1, -1, -1, -1);   // MD under backpressure
        run_burst(3, 0, 1, 0, 1'b1, 1'b0, -1, -1, -1);   // custom length 0, bad
        run_burst(0, 0, 0, 0, 1'b0, 1'b0, 3, 29, -1);    // continuous, stop in 4th
        run_burst(2, 0, 5, 1, 1'b0, 1'b1, -2, -1, -1);   // stop together with start
        run_burst(3, 192, 1, 0, 1'b0, 1'b0, -1, -1, -1); // custom 192 counts as md

        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("idle_stop_busy", DW'(busy), DW'(0));
        run_burst(1, 0, 2, 0, 1'b0, 1'b1, -1, -1, -1);

        for (int r = 0; r < 8; r++) begin
            run_burst($urandom_range(0, 3), $urandom_range(0, 400), $urandom_range(1, 3),
                      $urandom_range(0, 4), 1'($urandom), 1'b1, -1, -1, -1);
        end

        run_burst(0, 0, 1, 0, 1'b0, 1'b0, -1, -1, 9);    // reset mid-packet
        @(negedge clk);
        run_burst(0, 0, 1, 0, 1'b0, 1'b0, -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
